pc_window: RTL
==============

# pc_window

Parametrised program counter for the MIPS CPU fetch stage, successor to the fixed-window incrementing PC. Holds the instruction address inside a group-owned window [BASE, BASE+DEPTH-1] and supports stall, relative branch, absolute jump, halt/resume and out-of-window handling (wrap or fault). Drives instruction-memory address and tells the control unit whether fetch is live.

## Interface

Parameters:
- WIDTH, 32, address width in bits.
- BASE, 32'h940, window start and reset address (group 4: 4 × 0x250).
- DEPTH, 1024, window size in words; power of two, ≥ 2, BASE + DEPTH ≤ 2^WIDTH.
- WRAP, 1, 1 = out-of-window targets wrap modulo DEPTH; 0 = out-of-window target enters FAULT.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- en  in  1  advance enable; 0 = stall, Address held.
- branch_en  in  1  take relative branch this cycle.
- branch_off  in  WIDTH  signed two's-complement word offset.
- jump_en  in  1  take absolute jump this cycle.
- jump_addr  in  WIDTH  absolute jump target.
- halt  in  1  request halt.
- resume  in  1  leave HALT.
- Address  out  WIDTH  registered current PC.
- pc_next  out  WIDTH  combinational value Address takes at next edge.
- running  out  1  registered, 1 only in RUN.
- fault  out  1  registered, 1 only in FAULT.

## Operation

- States: INIT, RUN, HALT, FAULT. Encoding free.
- reset = 0 (any time, async): state INIT, Address = BASE, running = 0, fault = 0.
- INIT: Address held at BASE; next edge → RUN unconditionally (one settling cycle after reset release).
- RUN, per edge, priority order:
  - halt = 1 → HALT, Address held (halt beats everything, including jump).
  - en = 0 → stay RUN, Address held; branch/jump ignored.
  - jump_en = 1 → target = jump_addr (jump beats branch).
  - branch_en = 1 → target = Address + 1 + branch_off, mod 2^WIDTH.
  - else → target = Address + 1.
- Window check on target: in-window if BASE ≤ target ≤ BASE+DEPTH-1.
  - In-window: Address ← target.
  - Out-of-window, WRAP = 1: Address ← BASE + ((target − BASE) mod DEPTH), computed on the low log2(DEPTH) bits of (target − BASE) mod 2^WIDTH. Sequential increment from BASE+DEPTH-1 lands on BASE.
  - Out-of-window, WRAP = 0: → FAULT, Address held at the pre-fault value.
- HALT: Address held; resume = 1 → RUN next edge (no address update on that edge). halt and resume both 1 → stay HALT.
- FAULT: sticky; Address held; all inputs ignored; exit only by reset.
- pc_next always equals the value Address will take on the next edge given current inputs and state. In HALT, FAULT and INIT it equals Address.

## Timing

- All state and outputs update on rising clk; reset acts immediately without clk.
- Reset release: first edge INIT → RUN (Address still BASE, running = 1 after that edge); second edge gives first increment (BASE+1).
- Branch/jump latency: one edge; the new address is visible in Address the cycle after the request is sampled.
- running/fault change on the same edge as the state transition.
- No combinational path from inputs to Address/running/fault; pc_next is combinational from inputs and registers.

## Test plan

- Reset then release, en = 1: Address = 0x940 during reset and INIT, then 0x940 (RUN entry), 0x941, 0x942; running 0 → 1.
- WRAP = 1, run to 0xD3F, en = 1: next Address 0x940; branch_off = −3 at 0x941 → 0x93F wraps to 0xD3F.
- At 0x950 branch_off = −2 → 0x94F; same cycle jump_en with jump_addr 0xA00 → 0xA00 (jump wins); en = 0 with jump_en → held at 0x950.
- WRAP = 0, at 0x960 jump_addr = 0x800 → fault = 1, running = 0, Address stays 0x960 for ≥ 10 cycles regardless of inputs; reset clears to 0x940, fault = 0.
- halt at 0x945 → Address holds 0x945, running = 0; halt+resume together → stays HALT; resume alone → RUN, then 0x946.
- Assert reset asynchronously mid-cycle at 0xB00 → Address = 0x940 before next edge; pc_next tracks Address+1 in RUN at every cycle.

Source files
------------

// File: rtl/pc_window.sv
// Windowed program counter for the fetch stage: holds the PC inside [BASE, BASE+DEPTH-1]
// with stall, relative branch, absolute jump, halt/resume and wrap-or-fault on escape.
module pc_window #(
    parameter int unsigned      WIDTH = 32,
    parameter logic [WIDTH-1:0] BASE  = WIDTH'(32'h940),
    parameter int unsigned      DEPTH = 1024,
    parameter bit               WRAP  = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             branch_en,
    input  logic [WIDTH-1:0] branch_off,
    input  logic             jump_en,
    input  logic [WIDTH-1:0] jump_addr,
    input  logic             halt,
    input  logic             resume,
    output logic [WIDTH-1:0] Address,
    output logic [WIDTH-1:0] pc_next,
    output logic             running,
    output logic             fault
);

    localparam logic [WIDTH-1:0] MASK = WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        StInit,
        StRun,
        StHalt,
        StFault
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] offset;
    logic             in_window;

    // Candidate target; offset below BASE wraps high, so a clear upper field means in-window.
    always_comb begin
        if (jump_en) begin
            target = jump_addr;
        end else if (branch_en) begin
            target = addr_q + WIDTH'(1) + branch_off;
        end else begin
            target = addr_q + WIDTH'(1);
        end
        offset    = target - BASE;
        in_window = (offset & ~MASK) == '0;
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        unique case (state_q)
            StInit: state_d = StRun;
            StRun: begin
                if (halt) begin
                    state_d = StHalt;
                end else if (en) begin
                    if (in_window) begin
                        addr_d = target;
                    end else if (WRAP) begin
                        addr_d = BASE + (offset & MASK);
                    end else begin
                        state_d = StFault;
                    end
                end
            end
            StHalt: begin
                if (resume && !halt) begin
                    state_d = StRun;
                end
            end
            StFault: begin
                state_d = StFault;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StInit;
            addr_q  <= BASE;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    assign Address = addr_q;
    assign pc_next = addr_d;
    assign running = (state_q == StRun);
    assign fault   = (state_q == StFault);

endmodule
